// File: rtl/range_sort_engine.sv
// Multi-cycle selection sorter over a window of a register-file snapshot.
// Optional macro SORT_SIGNED_EN: compare elements as two's-complement signed.
//   state  | meaning
//   IDLE   | waiting for start, rf_out holds last result
//   LOAD   | clip length to n, clear used mask
//   SCAN   | one source element per cycle, track best unused candidate
//   PLACE  | store candidate into sbuf[i], mark it used
//   WRITE  | merge sbuf into snapshot, pulse done
module range_sort_engine #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      descending,
  input  logic [ADDR_W-1:0]         rd_addr,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [ADDR_W:0]           length,
  input  logic [DEPTH*DATA_W-1:0]   rf_in,
  output logic [DEPTH*DATA_W-1:0]   rf_out,
  output logic                      busy,
  output logic                      done
);

  localparam int CW = ADDR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_PLACE, S_WRITE} state_t;

  state_t                   state_q;
  logic [DATA_W-1:0]        snap_q [DEPTH];
  logic [DATA_W-1:0]        sbuf_q [DEPTH];
  logic                     desc_q;
  logic [CW-1:0]            rd_q, wr_q, len_q, n_q, i_q, j_q;
  logic [DEPTH-1:0]         used_q;
  logic [DATA_W-1:0]        cand_val_q;
  logic [ADDR_W-1:0]        cand_idx_q;
  logic                     found_q;
  logic [DEPTH*DATA_W-1:0]  rf_out_q;
  logic                     busy_q, done_q;

  logic [CW-1:0]            avail, n_calc, src_idx;
  logic [DATA_W-1:0]        elem;
  logic                     better;
  logic [DEPTH*DATA_W-1:0]  img_d;

  assign avail   = CW'(DEPTH) - rd_q;
  assign n_calc  = (len_q < avail) ? len_q : avail;
  assign src_idx = rd_q + j_q;
  assign elem    = snap_q[src_idx[ADDR_W-1:0]];

`ifdef SORT_SIGNED_EN
  assign better = desc_q ? ($signed(elem) > $signed(cand_val_q))
                         : ($signed(elem) < $signed(cand_val_q));
`else
  assign better = desc_q ? (elem > cand_val_q) : (elem < cand_val_q);
`endif

  // Destination entries past the end of the file are simply never matched.
  always_comb begin
    img_d = '0;
    for (int d = 0; d < DEPTH; d++) begin
      img_d[d*DATA_W +: DATA_W] = snap_q[d];
      if ((CW'(d) >= wr_q) && ((CW'(d) - wr_q) < n_q))
        img_d[d*DATA_W +: DATA_W] = sbuf_q[ADDR_W'(CW'(d) - wr_q)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      for (int k = 0; k < DEPTH; k++) begin
        snap_q[k] <= '0;
        sbuf_q[k] <= '0;
      end
      desc_q     <= 1'b0;
      rd_q       <= '0;
      wr_q       <= '0;
      len_q      <= '0;
      n_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      used_q     <= '0;
      cand_val_q <= '0;
      cand_idx_q <= '0;
      found_q    <= 1'b0;
      rf_out_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            for (int k = 0; k < DEPTH; k++)
              snap_q[k] <= rf_in[k*DATA_W +: DATA_W];
            desc_q  <= descending;
            rd_q    <= {1'b0, rd_addr};
            wr_q    <= {1'b0, wr_addr};
            len_q   <= length;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          n_q     <= n_calc;
          used_q  <= '0;
          i_q     <= '0;
          j_q     <= '0;
          found_q <= 1'b0;
          state_q <= (n_calc != '0) ? S_SCAN : S_WRITE;
        end
        S_SCAN: begin
          // Strict compare keeps the lowest index on ties, making the sort stable.
          if (!used_q[j_q[ADDR_W-1:0]] && (!found_q || better)) begin
            cand_val_q <= elem;
            cand_idx_q <= j_q[ADDR_W-1:0];
            found_q    <= 1'b1;
          end
          if (j_q == n_q - CW'(1))
            state_q <= S_PLACE;
          else
            j_q <= j_q + CW'(1);
        end
        S_PLACE: begin
          sbuf_q[i_q[ADDR_W-1:0]] <= cand_val_q;
          used_q[cand_idx_q]      <= 1'b1;
          i_q     <= i_q + CW'(1);
          j_q     <= '0;
          found_q <= 1'b0;
          state_q <= ((i_q + CW'(1)) < n_q) ? S_SCAN : S_WRITE;
        end
        S_WRITE: begin
          rf_out_q <= img_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rf_out = rf_out_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_range_sort_engine.sv
// Directed self-checking bench for range_sort_engine (DATA_W=4, DEPTH=8).
module tb_range_sort_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        descending;
  logic [2:0]  rd_addr, wr_addr;
  logic [3:0]  length;
  logic [31:0] rf_in, rf_out;
  logic        busy, done;

  int n_checks = 0;
  int n_errors = 0;

  range_sort_engine #(.DATA_W(4), .DEPTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .descending (descending),
    .rd_addr    (rd_addr),
    .wr_addr    (wr_addr),
    .length     (length),
    .rf_in      (rf_in),
    .rf_out     (rf_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Launch one sort, scramble inputs while busy, measure edges to done.
  task automatic do_sort(input string tag, input logic [31:0] img, input logic d,
                         input logic [2:0] ra, input logic [2:0] wa, input logic [3:0] len,
                         input int lat, input logic [31:0] exp_img, input logic poke);
    int edges;
    @(negedge clk);
    rf_in = img; descending = d; rd_addr = ra; wr_addr = wa; length = len; start = 1'b1;
    @(posedge clk); #1;
    start      = poke;
    rf_in      = ~img;
    descending = ~d;
    rd_addr    = ~ra;
    wr_addr    = ra;
    length     = 4'd8;
    check({tag, "_busy_hi"}, 32'(busy), 32'd1);
    edges = 0;
    while (!done && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(edges), 32'(lat));
    check({tag, "_rf_out"}, rf_out, exp_img);
    check({tag, "_busy_lo"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int extra;
    rst_n = 1'b0; start = 1'b0; descending = 1'b0;
    rd_addr = '0; wr_addr = '0; length = '0; rf_in = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rf_out", rf_out, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_sort("asc_full", 32'h4206_1537, 1'b0, 3'd0, 3'd0, 4'd8, 74, 32'h7654_3210, 1'b0);
    do_sort("desc_full", 32'h4206_1537, 1'b1, 3'd0, 3'd0, 4'd8, 74, 32'h0123_4567, 1'b0);

    // Asynchronous abort in the middle of a len=8 SCAN.
    @(negedge clk);
    rf_in = 32'h4206_1537; descending = 1'b0; rd_addr = 3'd0; wr_addr = 3'd0;
    length = 4'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_rf_out", rf_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_sort("desc_overlap", 32'h7654_3210, 1'b1, 3'd2, 3'd4, 4'd3, 14, 32'h7234_3210, 1'b0);
    do_sort("clip_src", 32'h8954_3210, 1'b0, 3'd6, 3'd7, 4'd5, 8, 32'h8954_3210, 1'b0);
    do_sort("clip_dst", 32'h1234_5678, 1'b0, 3'd0, 3'd6, 4'd4, 22, 32'h6534_5678, 1'b0);

    // Zero length with start held high throughout busy: must not queue a second run.
    do_sort("zero_len", 32'h8954_3210, 1'b0, 3'd3, 3'd1, 4'd0, 2, 32'h8954_3210, 1'b1);
    extra = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("ignored_start_done", 32'(extra), 32'd0);
    check("ignored_start_rf_out", rf_out, 32'h8954_3210);

`ifdef SORT_SIGNED_EN
    do_sort("signed", 32'h0000_01F2, 1'b0, 3'd0, 3'd0, 4'd3, 14, 32'h0000_021F, 1'b0);
`else
    do_sort("unsigned", 32'h0000_01F2, 1'b0, 3'd0, 3'd0, 4'd3, 14, 32'h0000_0F21, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/range_sort_engine.md
# range_sort_engine

Multi-cycle sorter that works on a window of the register file. It takes a snapshot of the whole file and sorts a source range of `length` entries, ascending or descending. It writes the sorted run into a destination range and returns the updated image with a one-cycle `done` pulse. It sits beside `regfile`, and the controller uses `done` as the sort-write permission.

## Interface
Parameters:
- `DATA_W`, 4, element width in bits.
- `DEPTH`, 8, number of register-file entries (≥2).
- `ADDR_W`, `$clog2(DEPTH)`, index width.

Ports:
- `clk`, in, 1, single clock, all state on rising edge.
- `rst_n`, in, 1, asynchronous active-low reset.
- `start`, in, 1, request; sampled only in IDLE.
- `descending`, in, 1, 0 = ascending, 1 = descending.
- `rd_addr`, in, `ADDR_W`, first source index.
- `wr_addr`, in, `ADDR_W`, first destination index.
- `length`, in, `ADDR_W+1`, requested element count (0..`DEPTH`).
- `rf_in`, in, `DEPTH*DATA_W`, flattened file; entry k at `[k*DATA_W +: DATA_W]`.
- `rf_out`, out, `DEPTH*DATA_W`, result image, same packing.
- `busy`, out, 1, high from the start-accept edge until the done edge.
- `done`, out, 1, one-cycle pulse when `rf_out` is valid.

## Operation
- **States:** IDLE, LOAD, SCAN, PLACE, WRITE.
- **IDLE:**
  - `start`=1 captures `rf_in`, `descending`, `rd_addr`, `wr_addr` and `length` into internal registers.
  - Sets `busy` and moves to LOAD.
- **LOAD:**
  - n = min(`length`, `DEPTH`−`rd_addr`). The source never wraps.
  - Clears the `used` mask and sets pass index i=0.
  - Moves to SCAN if n>0, otherwise to WRITE.
- **SCAN:**
  - Examines one source element per cycle, for j = 0..n−1.
  - The first unused element seen becomes the candidate.
  - A later unused element replaces the candidate only if strictly less (ascending) or strictly greater (descending). Ties keep the lowest index, so the sort is stable.
  - Moves to PLACE after j=n−1.
- **PLACE:**
  - Writes the candidate into sort buffer `sbuf[i]` and marks its index used.
  - i++. Returns to SCAN if i<n, otherwise moves to WRITE.
- **WRITE:**
  - `rf_out` = snapshot, with entry `wr_addr`+k replaced by `sbuf[k]` for every k<n where `wr_addr`+k<`DEPTH`. Destination entries past `DEPTH`−1 are dropped; there is no wrap.
  - Source and destination may overlap; the result is built from the snapshot only.
  - Raises `done` for one cycle, clears `busy`, returns to IDLE.
- Non-destination entries of `rf_out` always equal the snapshot.
- Changes on the inputs while `busy` have no effect. `start` while `busy` is ignored and is not queued.
- `rf_out` holds its value until the next WRITE.

## Timing
- **Reset values:** `rf_out`=0, `busy`=0, `done`=0, state IDLE, mask cleared.
- **Asynchronous reset mid-operation:** aborts at once; no partial `rf_out` update.
- **Latency:** `done` rises on edge n·(n+1)+2 after the start-sampling edge. n=0 gives 2 edges, n=8 gives 74. `done` lasts exactly 1 cycle.
- **Back-to-back:** `start` held high in the cycle `done` is high is sampled in IDLE on the next edge, giving 1 idle cycle between operations.
- Index arithmetic is done in `ADDR_W+1` bits, so `rd_addr`+`length` cannot overflow.

## Configuration
- **`SORT_SIGNED_EN` defined:** all SCAN comparisons treat elements as two's-complement signed `DATA_W`-bit values.
- **Not defined:** comparisons are unsigned.
- No other behaviour depends on the macro.

## Test plan
1. **Reset and idle outputs.** Assert `rst_n`=0 mid-SCAN of a len=8 sort -> `busy`=0, `done`=0 and `rf_out`=0 immediately. The next start runs to completion normally.
2. **Full ascending sort.** `rf_in`={7,3,5,1,6,0,2,4} (entries 0..7), rd=0, wr=0, len=8, asc -> exactly 74 edges later `done` pulses. `rf_out`={0,1,2,3,4,5,6,7}.
3. **Descending, overlapping ranges.** `rf_in`={0,1,2,3,4,5,6,7}, rd=2, wr=4, len=3, desc -> `rf_out`={0,1,2,3,4,3,2,7}. `done` comes 14 edges after the start edge.
4. **Clipping.** `rf_in`={0,1,2,3,4,5,9,8}, rd=6, wr=7, len=5, asc -> n=2, sorted run {8,9}. `rf_out`={0,1,2,3,4,5,9,8}, with only entry 7 written (value 8). `done` comes after 8 edges.
5. **Zero length and ignored start.** len=0 -> `done` after 2 edges and `rf_out`=`rf_in`. A `start` pulse while `busy`, with different ranges, produces no extra `done` and leaves the result unchanged.
6. **Signedness.** `rf_in`={2,F,1,…}, rd=0, wr=0, len=3, asc:
   - With `SORT_SIGNED_EN`: entries 0..2 = {F,1,2}.
   - Without it: entries 0..2 = {1,2,F}.
